softmax_seq_ctrl: RTL and testbench

Sequencer that feeds the 10-lane softmax datapath from a 16-bit element stream and returns its results as a stream. It collects one 10-element frame, presents it on the datapath's parallel x inputs, and holds it stable for the datapath's fixed pipeline latency. It then captures the 10 results and drains them one per handshake. Only one frame is in flight at a time, because the datapath reads x directly in a later pipeline stage.

---
 rtl/softmax_seq_ctrl_if.sv | 27 ++
 rtl/softmax_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_softmax_seq_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/softmax_seq_ctrl_if.sv
// Stream and datapath signal bundle for softmax_seq_ctrl.
// The slave modport is the controller side; master is the feeding/consuming side.
interface softmax_seq_ctrl_if #(
  parameter int N  = 10,
  parameter int DW = 16
);
  logic            s_tvalid;
  logic            s_tready;
  logic [DW-1:0]   s_tdata;
  logic            s_tlast;
  logic [N*DW-1:0] dp_x;
  logic [N*DW-1:0] dp_result;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, dp_result, m_tready,
    output s_tready, dp_x, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, dp_result, m_tready,
    input  s_tready, dp_x, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// Frame sequencer for the 10-lane softmax datapath: collects one frame onto dp_x,
// waits out the datapath latency plus one margin cycle, then drains the results.
module softmax_seq_ctrl #(
  parameter int N          = 10,
  parameter int DW         = 16,
  parameter int DP_LATENCY = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  softmax_seq_ctrl_if.slave  io,
  output logic               busy,
  output logic               frame_err
);

  localparam int IW = 4;
  localparam int CW = (DP_LATENCY < 1) ? 1 : $clog2(DP_LATENCY + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DP_LATENCY);
  // Most negative value: exp() of a padded lane contributes ~0 to the sum.
  localparam logic [DW-1:0] PAD_VAL  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WAIT    = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   oidx_q;
  logic [CW-1:0]   cnt_q;
  logic [N*DW-1:0] x_q;
  logic [N*DW-1:0] res_q;
  logic            s_tready_q;
  logic            m_tvalid_q;
  logic [DW-1:0]   m_tdata_q;
  logic            m_tlast_q;
  logic            busy_q;
  logic            frame_err_q;

  logic            accept_s;
  logic            launch_s;
  logic [IW-1:0]   oidx_inc_s;

  function automatic logic [DW-1:0] lane_sel(input logic [N*DW-1:0] v,
                                             input logic [IW-1:0]   i);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (i == IW'(k)) r = v[k*DW +: DW];
    end
    return r;
  endfunction

  assign accept_s   = (state_q == S_COLLECT) && s_tready_q && io.s_tvalid;
  assign launch_s   = accept_s && ((idx_q == LAST_IDX) || io.s_tlast);
  assign oidx_inc_s = oidx_q + 4'd1;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_COLLECT;
      idx_q       <= '0;
      oidx_q      <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      res_q       <= '0;
      s_tready_q  <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          s_tready_q <= 1'b1;
          if (accept_s) begin
            // A short frame pads every lane above the current one on the same edge.
            for (int k = 0; k < N; k++) begin
              if (idx_q == IW'(k)) begin
                x_q[k*DW +: DW] <= io.s_tdata;
              end else if (io.s_tlast && (IW'(k) > idx_q)) begin
                x_q[k*DW +: DW] <= PAD_VAL;
              end
            end
            busy_q <= 1'b1;
            if (launch_s) begin
              state_q     <= S_WAIT;
              cnt_q       <= CNT_LOAD;
              idx_q       <= '0;
              s_tready_q  <= 1'b0;
              frame_err_q <= (idx_q == LAST_IDX) && !io.s_tlast;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end

        S_WAIT: begin
          s_tready_q <= 1'b0;
          busy_q     <= 1'b1;
          if (cnt_q == '0) begin
            res_q      <= io.dp_result;
            oidx_q     <= '0;
            state_q    <= S_DRAIN;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= io.dp_result[DW-1:0];
            m_tlast_q  <= (LAST_IDX == 4'd0);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_DRAIN: begin
          s_tready_q <= 1'b0;
          if (io.m_tready) begin
            if (oidx_q == LAST_IDX) begin
              state_q    <= S_COLLECT;
              oidx_q     <= '0;
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              s_tready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              oidx_q    <= oidx_inc_s;
              m_tdata_q <= lane_sel(res_q, oidx_inc_s);
              m_tlast_q <= (oidx_inc_s == LAST_IDX);
            end
          end
        end

        default: begin
          state_q    <= S_COLLECT;
          idx_q      <= '0;
          oidx_q     <= '0;
          s_tready_q <= 1'b0;
          m_tvalid_q <= 1'b0;
          m_tlast_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign io.s_tready = s_tready_q;
  assign io.dp_x     = x_q;
  assign io.m_tvalid = m_tvalid_q;
  assign io.m_tdata  = m_tdata_q;
  assign io.m_tlast  = m_tlast_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl; the datapath stand-in returns x plus a cycle
// stamp, so each result also encodes the edge on which it was captured.
module tb_softmax_seq_ctrl;
  localparam int N   = 10;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        busy;
  logic        frame_err;
  int unsigned cyc     = 0;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          got;
  int          got2;
  logic [DW-1:0] fdat [0:2][0:N-1];
  int unsigned   lst  [0:2];

  softmax_seq_ctrl_if #(.N(N), .DW(DW)) bus ();

  softmax_seq_ctrl #(.N(N), .DW(DW), .DP_LATENCY(LAT)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .io        (bus),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [N*DW-1:0] stamp(input logic [N*DW-1:0] x, input logic [DW-1:0] s);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = x[i*DW +: DW] + s;
    return r;
  endfunction

  // Result seen at edge E was produced from dp_x after edge E-1, stamped E-1.
  always @(negedge aclk) bus.dp_result <= stamp(bus.dp_x, cyc[DW-1:0]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int fr, input int cnt, input bit with_last, input bit exp_err);
    int k = 0;
    int guard = 0;
    bit acc;
    for (int j = cnt; j < N; j++) fdat[fr][j] = 16'h8000;
    while (k < cnt && guard < 400) begin
      @(negedge aclk);
      guard++;
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = fdat[fr][k];
      bus.s_tlast  = with_last && (k == cnt - 1);
      acc = bus.s_tready;
      @(posedge aclk);
      if (acc) k++;
    end
    #1 lst[fr] = cyc;
    chk("send_count", k, cnt);
    @(negedge aclk);
    chk("s_tready_launch", bus.s_tready, 1'b0);
    chk("busy_launch", busy, 1'b1);
    chk("frame_err_launch", frame_err, exp_err);
    for (int i = 0; i < N; i++) chk("dp_x_lane", bus.dp_x[i*DW +: DW], fdat[fr][i]);
    @(negedge aclk);
    chk("frame_err_drop", frame_err, 1'b0);
  endtask

  task automatic recv(input int fr, input int mode, input int stop_at, output int n_got);
    int guard = 0;
    logic [DW-1:0] e;
    n_got = 0;
    while (n_got < stop_at && guard < 500) begin
      @(negedge aclk);
      guard++;
      bus.m_tready = (mode == 0) ? 1'b1 : guard[0];
      if (bus.m_tvalid) begin
        e = fdat[fr][n_got] + 16'(lst[fr] + 4);
        chk("m_tdata", bus.m_tdata, e);
        chk("m_tlast", bus.m_tlast, (n_got == N - 1));
        chk("s_tready_drain", bus.s_tready, 1'b0);
        if (bus.m_tready) n_got++;
      end
    end
    chk("recv_count", n_got, stop_at);
  endtask

  task automatic idle_checks(input string tag);
    @(negedge aclk);
    chk({tag, "_m_tvalid"}, bus.m_tvalid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_s_tready"}, bus.s_tready, 1'b1);
  endtask

  task automatic reset_pulse(input string tag);
    aresetn = 1'b0;
    #1;
    chk({tag, "_s_tready"}, bus.s_tready, 1'b0);
    chk({tag, "_m_tvalid"}, bus.m_tvalid, 1'b0);
    chk({tag, "_m_tdata"}, bus.m_tdata, 16'h0000);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_dp_x"}, |bus.dp_x, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge aclk);
      chk({tag, "_no_m_tvalid"}, bus.m_tvalid, 1'b0);
    end
    chk({tag, "_s_tready_back"}, bus.s_tready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d limit=10000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_s_tready", bus.s_tready, 1'b0);
    chk("rst_m_tvalid", bus.m_tvalid, 1'b0);
    chk("rst_m_tlast", bus.m_tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_dp_x", |bus.dp_x, 1'b0);
    aresetn = 1'b1;
    #1 chk("s_tready_at_release", bus.s_tready, 1'b0);
    @(negedge aclk);
    chk("s_tready_after_release", bus.s_tready, 1'b1);

    // Full frame, m_tready held high: drain ends exactly 15 edges after launch.
    for (int i = 0; i < N; i++) fdat[0][i] = 16'((i + 1) << 8);
    send(0, N, 1'b1, 1'b0);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    recv(0, 0, N, got);
    idle_checks("full_end");
    chk("full_cycles", cyc - lst[0], 15);

    // Same frame with m_tready toggling every cycle.
    for (int i = 0; i < N; i++) fdat[1][i] = 16'((i + 1) << 8);
    send(1, N, 1'b1, 1'b0);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    recv(1, 1, N, got);
    idle_checks("bp_end");

    // Short frame of 3: lanes 3..9 padded with 16'h8000.
    fdat[2][0] = 16'h1111; fdat[2][1] = 16'h2222; fdat[2][2] = 16'h3333;
    send(2, 3, 1'b1, 1'b0);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    recv(2, 0, N, got);
    idle_checks("short_end");

    // Missing tlast, followed by a normal frame.
    for (int i = 0; i < N; i++) fdat[0][i] = 16'(16'hF000 + i * 16'h0123);
    send(0, N, 1'b0, 1'b1);
    bus.s_tvalid = 1'b0;
    recv(0, 0, N, got);
    for (int i = 0; i < N; i++) fdat[1][i] = 16'(16'h0010 * (i + 1));
    send(1, N, 1'b1, 1'b0);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    recv(1, 0, N, got);
    idle_checks("noerr_end");

    // Reset while waiting on the datapath.
    for (int i = 0; i < N; i++) fdat[2][i] = 16'(16'h7000 + i);
    send(2, N, 1'b1, 1'b0);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    reset_pulse("rst_wait");

    // Reset while the fourth result beat is presented.
    for (int i = 0; i < N; i++) fdat[0][i] = 16'(16'h1000 + i * 16'h0011);
    send(0, N, 1'b1, 1'b0);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    recv(0, 0, 3, got);
    @(negedge aclk);
    chk("beat4_valid", bus.m_tvalid, 1'b1);
    chk("beat4_data", bus.m_tdata, 16'(fdat[0][3] + 16'(lst[0] + 4)));
    reset_pulse("rst_drain");
    for (int i = 0; i < N; i++) fdat[1][i] = 16'(16'h0A00 - i * 16'h0100);
    send(1, N, 1'b1, 1'b0);
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    recv(1, 0, N, got);
    idle_checks("post_rst_end");

    // s_tvalid held high across three back-to-back frames.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) fdat[f][i] = 16'(16'h2000 + f * 16'h0100 + i);
    fork
      begin
        send(0, N, 1'b1, 1'b0);
        send(1, N, 1'b1, 1'b0);
        send(2, N, 1'b1, 1'b0);
        bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      end
      begin
        recv(0, 0, N, got2);
        recv(1, 0, N, got2);
        recv(2, 0, N, got2);
      end
    join
    idle_checks("cont_end");

    repeat (2) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
